// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the two-requester APB master arbiter.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b01,
        ST_ACCESS = 2'b10,
        ST_DONE   = 2'b11
    } apb_state_e;

    localparam int unsigned APB_DATA_W = 32;
    localparam int unsigned APB_STRB_W = 4;
    localparam int unsigned APB_PROT_W = 3;
    localparam int unsigned TO_W       = 8;

    // Reads never drive byte strobes onto the bus.
    function automatic logic [APB_STRB_W-1:0] apb_strb(input logic                  write,
                                                       input logic [APB_STRB_W-1:0] strb);
        return write ? strb : '0;
    endfunction

endpackage

// File: rtl/apb_master_arbiter_if.sv
// Requester-side and APB-side signals of the arbiter, bundled with modports.
interface apb_master_arbiter_if
    import apb_arb_pkg::*;
#(
    parameter int unsigned ADDRWIDTH = 16
) ();

    logic                  req0_valid;
    logic [ADDRWIDTH-1:0]  req0_addr;
    logic                  req0_write;
    logic [APB_DATA_W-1:0] req0_wdata;
    logic [APB_STRB_W-1:0] req0_strb;
    logic [APB_PROT_W-1:0] req0_prot;
    logic                  req0_done;
    logic [APB_DATA_W-1:0] req0_rdata;
    logic                  req0_err;

    logic                  req1_valid;
    logic [ADDRWIDTH-1:0]  req1_addr;
    logic                  req1_write;
    logic [APB_DATA_W-1:0] req1_wdata;
    logic [APB_STRB_W-1:0] req1_strb;
    logic [APB_PROT_W-1:0] req1_prot;
    logic                  req1_done;
    logic [APB_DATA_W-1:0] req1_rdata;
    logic                  req1_err;

    logic [ADDRWIDTH-1:0]  paddr;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [APB_DATA_W-1:0] pwdata;
    logic [APB_STRB_W-1:0] pstrb;
    logic [APB_PROT_W-1:0] pprot;
    logic                  pready;
    logic [APB_DATA_W-1:0] prdata;
    logic                  pslverr;

    modport master (
        input  req0_valid, req0_addr, req0_write, req0_wdata, req0_strb, req0_prot,
        output req0_done, req0_rdata, req0_err,
        input  req1_valid, req1_addr, req1_write, req1_wdata, req1_strb, req1_prot,
        output req1_done, req1_rdata, req1_err,
        output paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
        input  pready, prdata, pslverr
    );

    modport slave (
        output req0_valid, req0_addr, req0_write, req0_wdata, req0_strb, req0_prot,
        input  req0_done, req0_rdata, req0_err,
        output req1_valid, req1_addr, req1_write, req1_wdata, req1_strb, req1_prot,
        input  req1_done, req1_rdata, req1_err,
        input  paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
        output pready, prdata, pslverr
    );

endinterface

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin picker; the caller owns the last-grant register.
module rr_arbiter_2 (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic [1:0] gnt_o
);

    // Single requester wins outright; on a tie the one not served last wins.
    always_comb begin
        gnt_o = 2'b00;
        unique case (req_i)
            2'b00: gnt_o = 2'b00;
            2'b01: gnt_o = 2'b01;
            2'b10: gnt_o = 2'b10;
            2'b11: gnt_o = last_grant_i ? 2'b01 : 2'b10;
        endcase
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB master port between two requesters with round-robin arbitration.
// Optional ACCESS-phase timeout is compiled in with `define APB_TIMEOUT_EN.
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int unsigned ADDRWIDTH      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                 hclk,
    input  logic                 hrst,
    input  logic                 pclk_en,
    apb_master_arbiter_if.master bus
);

    apb_state_e            state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  owner_q, owner_d;
    logic [ADDRWIDTH-1:0]  paddr_q, paddr_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [APB_DATA_W-1:0] pwdata_q, pwdata_d;
    logic [APB_STRB_W-1:0] pstrb_q, pstrb_d;
    logic [APB_PROT_W-1:0] pprot_q, pprot_d;
    logic                  done0_q, done0_d, done1_q, done1_d;
    logic [APB_DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic                  err0_q, err0_d, err1_q, err1_d;

    logic [1:0]            gnt;
    logic                  win;
    logic                  cpl;
    logic [APB_DATA_W-1:0] cpl_rdata;
    logic                  cpl_err;

`ifdef APB_TIMEOUT_EN
    logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
`else
    logic                  unused_timeout;
    assign unused_timeout = ^TO_W'(TIMEOUT_CYCLES);
`endif

    rr_arbiter_2 u_rr (
        .req_i        ({bus.req1_valid, bus.req0_valid}),
        .last_grant_i (last_grant_q),
        .gnt_o        (gnt)
    );

    assign win = gnt[1];

    // Next-state, APB output and completion logic.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        paddr_d      = paddr_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        pwrite_d     = pwrite_q;
        pwdata_d     = pwdata_q;
        pstrb_d      = pstrb_q;
        pprot_d      = pprot_q;
        done0_d      = 1'b0;
        done1_d      = 1'b0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        err0_d       = err0_q;
        err1_d       = err1_q;
        cpl          = 1'b0;
        cpl_rdata    = '0;
        cpl_err      = 1'b0;
`ifdef APB_TIMEOUT_EN
        to_cnt_d     = to_cnt_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (pclk_en && (gnt != 2'b00)) begin
                    owner_d      = win;
                    last_grant_d = win;
                    paddr_d      = (win ? bus.req1_addr : bus.req0_addr) & ~ADDRWIDTH'(3);
                    pwrite_d     = win ? bus.req1_write : bus.req0_write;
                    pwdata_d     = win ? bus.req1_wdata : bus.req0_wdata;
                    pstrb_d      = win ? apb_strb(bus.req1_write, bus.req1_strb)
                                       : apb_strb(bus.req0_write, bus.req0_strb);
                    pprot_d      = win ? bus.req1_prot : bus.req0_prot;
                    psel_d       = 1'b1;
                    state_d      = ST_SETUP;
`ifdef APB_TIMEOUT_EN
                    to_cnt_d     = '0;
`endif
                end
            end
            ST_SETUP: begin
                if (pclk_en) begin
                    penable_d = 1'b1;
                    state_d   = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (pclk_en) begin
                    if (bus.pready) begin
                        cpl       = 1'b1;
                        cpl_rdata = pwrite_q ? '0 : bus.prdata;
                        cpl_err   = bus.pslverr;
                    end
`ifdef APB_TIMEOUT_EN
                    else if ((9'(to_cnt_q) + 9'd1) == 9'(TIMEOUT_CYCLES)) begin
                        cpl     = 1'b1;
                        cpl_err = 1'b1;
                    end else begin
                        to_cnt_d = to_cnt_q + 8'd1;
                    end
`endif
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Completion ends the APB transfer and reports only to the owner.
        if (cpl) begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
            state_d   = ST_DONE;
            if (owner_q) begin
                done1_d  = 1'b1;
                rdata1_d = cpl_rdata;
                err1_d   = cpl_err;
            end else begin
                done0_d  = 1'b1;
                rdata0_d = cpl_rdata;
                err0_d   = cpl_err;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge hclk) begin
        if (hrst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            paddr_q      <= '0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            pwdata_q     <= '0;
            pstrb_q      <= '0;
            pprot_q      <= '0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
`ifdef APB_TIMEOUT_EN
            to_cnt_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            paddr_q      <= paddr_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            pwrite_q     <= pwrite_d;
            pwdata_q     <= pwdata_d;
            pstrb_q      <= pstrb_d;
            pprot_q      <= pprot_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            err0_q       <= err0_d;
            err1_q       <= err1_d;
`ifdef APB_TIMEOUT_EN
            to_cnt_q     <= to_cnt_d;
`endif
        end
    end

    assign bus.paddr      = paddr_q;
    assign bus.psel       = psel_q;
    assign bus.penable    = penable_q;
    assign bus.pwrite     = pwrite_q;
    assign bus.pwdata     = pwdata_q;
    assign bus.pstrb      = pstrb_q;
    assign bus.pprot      = pprot_q;
    assign bus.req0_done  = done0_q;
    assign bus.req0_rdata = rdata0_q;
    assign bus.req0_err   = err0_q;
    assign bus.req1_done  = done1_q;
    assign bus.req1_rdata = rdata1_q;
    assign bus.req1_err   = err1_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Self-checking bench for apb_master_arbiter: directed vector table, hand-written
// contention/reset/timeout sequences and randomized traffic against a transfer-level model.
module tb_apb_master_arbiter;

    localparam int unsigned AW = 16;
    localparam int unsigned TO = 4;

    typedef struct packed {
        logic [15:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
    } req_t;

    typedef struct {
        int          who;
        req_t        r;
        logic [31:0] prdata;
        logic        slverr;
        int          k;
        int          w;
        logic [15:0] e_paddr;
        logic [3:0]  e_pstrb;
        logic [31:0] e_rdata;
        logic        e_err;
        int          e_lat;
        int          e_psel;
        int          e_pen;
    } vec_t;

    logic hclk = 1'b0;
    logic hrst;
    logic pclk_en;

    apb_master_arbiter_if #(.ADDRWIDTH(AW)) bus ();

    apb_master_arbiter #(
        .ADDRWIDTH      (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .hclk    (hclk),
        .hrst    (hrst),
        .pclk_en (pclk_en),
        .bus     (bus)
    );

    always #5 hclk = ~hclk;

    int total = 0;
    int bad   = 0;

    // Stimulus state
    req_t        rq [2];
    logic [1:0]  vld;
    int          gap [2];
    logic        sl_pready;
    logic [31:0] sl_prdata;
    logic        sl_pslverr;

    // Reference model: expected APB bus and requester-side results
    logic        m_psel, m_pen, m_cool, m_last, m_owner;
    int          m_ticks;
    logic [15:0] m_paddr;
    logic        m_pwrite;
    logic [31:0] m_pwdata;
    logic [3:0]  m_pstrb;
    logic [2:0]  m_pprot;
    logic [1:0]  m_done;
    logic [31:0] m_rdata [2];
    logic [1:0]  m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic req_t rand_req();
        req_t r;
        r.addr  = 16'($urandom);
        r.write = 1'($urandom);
        r.wdata = $urandom;
        r.strb  = 4'($urandom);
        r.prot  = 3'($urandom);
        return r;
    endfunction

    task automatic drive();
        bus.req0_valid = vld[0];
        bus.req0_addr  = rq[0].addr;
        bus.req0_write = rq[0].write;
        bus.req0_wdata = rq[0].wdata;
        bus.req0_strb  = rq[0].strb;
        bus.req0_prot  = rq[0].prot;
        bus.req1_valid = vld[1];
        bus.req1_addr  = rq[1].addr;
        bus.req1_write = rq[1].write;
        bus.req1_wdata = rq[1].wdata;
        bus.req1_strb  = rq[1].strb;
        bus.req1_prot  = rq[1].prot;
        bus.pready     = sl_pready;
        bus.prdata     = sl_prdata;
        bus.pslverr    = sl_pslverr;
    endtask

    task automatic finish_xfer(input logic [31:0] rd, input logic er);
        m_psel           = 1'b0;
        m_pen            = 1'b0;
        m_cool           = 1'b1;
        m_done[m_owner]  = 1'b1;
        m_rdata[m_owner] = rd;
        m_err[m_owner]   = er;
    endtask

    // One hclk edge of the transfer-level model, using the inputs held across that edge.
    task automatic model_edge();
        m_done = 2'b00;
        if (hrst) begin
            m_psel = 0; m_pen = 0; m_cool = 0; m_last = 1; m_owner = 0; m_ticks = 0;
            m_paddr = '0; m_pwrite = 0; m_pwdata = '0; m_pstrb = '0; m_pprot = '0;
            m_rdata[0] = '0; m_rdata[1] = '0; m_err = 2'b00;
        end else if (m_cool) begin
            m_cool = 1'b0;
        end else if (!m_psel) begin
            if (pclk_en && vld != 2'b00) begin
                m_owner  = (vld == 2'b11) ? ~m_last : vld[1];
                m_last   = m_owner;
                m_psel   = 1'b1;
                m_pen    = 1'b0;
                m_paddr  = rq[m_owner].addr & ~16'h3;
                m_pwrite = rq[m_owner].write;
                m_pwdata = rq[m_owner].wdata;
                m_pstrb  = rq[m_owner].write ? rq[m_owner].strb : 4'h0;
                m_pprot  = rq[m_owner].prot;
            end
        end else if (!m_pen) begin
            if (pclk_en) begin
                m_pen   = 1'b1;
                m_ticks = 0;
            end
        end else if (pclk_en) begin
            if (sl_pready) finish_xfer(m_pwrite ? 32'h0 : sl_prdata, sl_pslverr);
`ifdef APB_TIMEOUT_EN
            else if (m_ticks + 1 == TO) finish_xfer(32'h0, 1'b1);
`endif
            else m_ticks++;
        end
    endtask

    task automatic compare_all();
        check("psel",       32'(bus.psel),       32'(m_psel));
        check("penable",    32'(bus.penable),    32'(m_pen));
        check("paddr",      32'(bus.paddr),      32'(m_paddr));
        check("pwrite",     32'(bus.pwrite),     32'(m_pwrite));
        check("pwdata",     bus.pwdata,          m_pwdata);
        check("pstrb",      32'(bus.pstrb),      32'(m_pstrb));
        check("pprot",      32'(bus.pprot),      32'(m_pprot));
        check("req0_done",  32'(bus.req0_done),  32'(m_done[0]));
        check("req1_done",  32'(bus.req1_done),  32'(m_done[1]));
        check("req0_rdata", bus.req0_rdata,      m_rdata[0]);
        check("req1_rdata", bus.req1_rdata,      m_rdata[1]);
        check("req0_err",   32'(bus.req0_err),   32'(m_err[0]));
        check("req1_err",   32'(bus.req1_err),   32'(m_err[1]));
    endtask

    task automatic step();
        drive();
        @(posedge hclk);
        #1;
        model_edge();
        compare_all();
    endtask

    task automatic do_reset();
        hrst = 1'b1;
        vld  = 2'b00;
        step();
        step();
        hrst = 1'b0;
    endtask

    // Requesters: after a completion either re-request at once or go quiet for a while.
    task automatic service_reqs(input int reissue_pct);
        for (int n = 0; n < 2; n++) begin
            if (m_done[n]) begin
                if (int'($urandom_range(0, 99)) < reissue_pct) begin
                    rq[n] = rand_req();
                end else begin
                    vld[n] = 1'b0;
                    gap[n] = int'($urandom_range(0, 4));
                end
            end else if (!vld[n]) begin
                if (gap[n] == 0) begin
                    vld[n] = 1'b1;
                    rq[n]  = rand_req();
                end else begin
                    gap[n]--;
                end
            end
        end
    endtask

    vec_t        vt [5];
    vec_t        v;
    int          ticks, lat, pc, ec, kper;
    logic        got, ok, pen_before;
    logic [15:0] seen_addr;
    logic [3:0]  seen_strb;
    logic [31:0] rd;
    logic        er;
    int          order [$];

    initial begin
        vt[0] = '{0, '{16'h0010, 1'b0, 32'h0, 4'hF, 3'd0}, 32'hDEADBEEF, 1'b0, 1, 0,
                  16'h0010, 4'h0, 32'hDEADBEEF, 1'b0, 3, 2, 1};
        vt[1] = '{1, '{16'h1236, 1'b1, 32'hA5A5A5A5, 4'b0011, 3'd5}, 32'h12345678, 1'b0, 4, 2,
                  16'h1234, 4'b0011, 32'h0, 1'b0, 17, 16, 12};
        vt[2] = '{0, '{16'h2000, 1'b0, 32'h0, 4'hF, 3'd1}, 32'h0BADF00D, 1'b1, 2, 1,
                  16'h2000, 4'h0, 32'h0BADF00D, 1'b1, 7, 6, 4};
        vt[3] = '{0, '{16'h2004, 1'b1, 32'h600DCAFE, 4'hF, 3'd2}, 32'hFFFFFFFF, 1'b0, 1, 0,
                  16'h2004, 4'hF, 32'h0, 1'b0, 3, 2, 1};
        vt[4] = '{1, '{16'hFFFF, 1'b0, 32'h0, 4'h3, 3'd7}, 32'hCAFEF00D, 1'b0, 3, 0,
                  16'hFFFC, 4'h0, 32'hCAFEF00D, 1'b0, 7, 6, 3};

        rq[0] = '0; rq[1] = '0; vld = 2'b00; gap[0] = 0; gap[1] = 0;
        pclk_en = 1'b0; sl_pready = 1'b1; sl_prdata = '0; sl_pslverr = 1'b0;
        do_reset();
        check("reset psel", 32'(bus.psel), 32'h0);
        check("reset req0_done", 32'(bus.req0_done), 32'h0);

        // Directed single transfers.
        for (int i = 0; i < 5; i++) begin
            v = vt[i];
            rq[v.who] = v.r;
            vld[v.who] = 1'b1;
            sl_prdata = v.prdata;
            sl_pslverr = v.slverr;
            ticks = 0; lat = 0; pc = 0; ec = 0; got = 0;
            seen_addr = '0; seen_strb = '0; rd = '0; er = 1'b0;
            for (int s = 1; s <= 60 && !got; s++) begin
                pclk_en = ((s - 1) % v.k) == 0;
                sl_pready = !(bus.penable && ticks < v.w);
                pen_before = bus.penable;
                step();
                if (pen_before && pclk_en && !sl_pready) ticks++;
                if (bus.psel) begin
                    pc++;
                    if (pc == 1) begin
                        seen_addr = bus.paddr;
                        seen_strb = bus.pstrb;
                    end
                end
                if (bus.penable) ec++;
                if ((v.who == 0) ? bus.req0_done : bus.req1_done) begin
                    got = 1'b1;
                    lat = s;
                    rd  = (v.who == 0) ? bus.req0_rdata : bus.req1_rdata;
                    er  = (v.who == 0) ? bus.req0_err : bus.req1_err;
                end
            end
            vld[v.who] = 1'b0;
            pclk_en = 1'b0;
            step();
            check("vec done latency", 32'(lat), 32'(v.e_lat));
            check("vec psel cycles", 32'(pc), 32'(v.e_psel));
            check("vec penable cycles", 32'(ec), 32'(v.e_pen));
            check("vec paddr", 32'(seen_addr), 32'(v.e_paddr));
            check("vec pstrb", 32'(seen_strb), 32'(v.e_pstrb));
            check("vec rdata", rd, v.e_rdata);
            check("vec err", 32'(er), 32'(v.e_err));
        end

        // Contention: both requesters valid from reset, re-requesting continuously.
        do_reset();
        rq[0] = '{16'h0100, 1'b1, 32'h11111111, 4'hF, 3'd0};
        rq[1] = '{16'h0200, 1'b1, 32'h22222222, 4'hF, 3'd1};
        vld = 2'b11; pclk_en = 1'b1; sl_pready = 1'b1; sl_pslverr = 1'b0;
        for (int s = 0; s < 30; s++) begin
            step();
            if (bus.req0_done) order.push_back(0);
            if (bus.req1_done) order.push_back(1);
        end
        check("contention grant count", 32'(order.size() >= 6), 32'h1);
        for (int i = 0; i < order.size() && i < 6; i++) begin
            check("contention order", 32'(order[i]), 32'(i % 2));
        end
        vld = 2'b00;
        for (int s = 0; s < 6; s++) step();

        // Reset while waiting in ACCESS.
        rq[0] = '{16'h0040, 1'b0, 32'h0, 4'hF, 3'd0};
        vld = 2'b01; pclk_en = 1'b1; sl_pready = 1'b0; ok = 1'b0;
        for (int s = 0; s < 10 && !ok; s++) begin
            step();
            if (bus.penable) ok = 1'b1;
        end
        check("reach access", 32'(ok), 32'h1);
        step();
        hrst = 1'b1;
        step();
        check("mid-reset psel", 32'(bus.psel), 32'h0);
        check("mid-reset penable", 32'(bus.penable), 32'h0);
        check("mid-reset done", 32'({bus.req1_done, bus.req0_done}), 32'h0);
        hrst = 1'b0;
        rq[1] = '{16'h0080, 1'b0, 32'h0, 4'hF, 3'd0};
        vld = 2'b11; sl_pready = 1'b1;
        step();
        check("first grant after reset", 32'(bus.paddr), 32'h0040);
        for (int s = 0; s < 12; s++) begin
            step();
            service_reqs(50);
        end

`ifdef APB_TIMEOUT_EN
        // Slave never ready: the transfer aborts on the TO-th ACCESS tick.
        do_reset();
        rq[0] = '{16'h0300, 1'b0, 32'h0, 4'hF, 3'd0};
        vld = 2'b01; pclk_en = 1'b1; sl_pready = 1'b0; sl_prdata = 32'hFFFFFFFF; lat = 0;
        for (int s = 1; s <= 20 && lat == 0; s++) begin
            step();
            if (bus.req0_done) begin
                lat = s;
                rd  = bus.req0_rdata;
                er  = bus.req0_err;
            end
        end
        vld = 2'b00;
        step();
        check("timeout latency", 32'(lat), 32'(2 + TO));
        check("timeout rdata", rd, 32'h0);
        check("timeout err", 32'(er), 32'h1);
`endif

        // Randomized traffic with varying PCLK ratio.
        sl_pready = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            kper = 1 + (c / 500) % 4;
            pclk_en = (kper == 1) ? 1'b1 : ($urandom_range(0, kper - 1) == 0);
            sl_pready  = ($urandom_range(0, 3) != 0);
            sl_prdata  = $urandom;
            sl_pslverr = ($urandom_range(0, 7) == 0);
            step();
            service_reqs(50);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
